// File: rtl/irq_encoder_4to2.sv
// ============================================================================
// Module      : irq_encoder_4to2
// Description : Registered 4-to-2 priority encoder with sticky pending
//               requests and an ACK handshake. Define IRQ_ENC_ROUND_ROBIN_EN
//               for rotating priority; default is fixed priority 3>2>1>0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_encoder_4to2 (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       EI_L,
    input  logic [3:0] I_L,
    input  logic       ACK,
    output logic       A,
    output logic       B,
    output logic       GS_L,
    output logic       EO_L,
    output logic [3:0] PEND
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0] r_state;
    logic [3:0] r_pend;
    logic [1:0] r_idx;
    logic       r_gs_l;
    logic       r_eo_l;

    logic [0:0] w_state_nxt;
    logic [3:0] w_pend_nxt;
    logic [1:0] w_idx_nxt;
    logic       w_gs_l_nxt;
    logic [3:0] w_req;
    logic [3:0] w_clr;
    logic [1:0] w_win;

    assign w_req = EI_L ? 4'b0000 : ~I_L;

`ifdef IRQ_ENC_ROUND_ROBIN_EN
    logic [1:0] r_last;

    // Descending search starting just below the last granted index.
    always_comb begin
        logic       v_found;
        logic [1:0] v_cand;
        w_win   = 2'd0;
        v_found = 1'b0;
        v_cand  = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            v_cand = r_last - 2'(i);
            if (!v_found && r_pend[v_cand]) begin
                w_win   = v_cand;
                v_found = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_last <= 2'd0;
        end else if (r_state == ST_GRANT && ACK) begin
            r_last <= r_idx;
        end
    end
`else
    always_comb begin
        w_win = 2'd0;
        if (r_pend[3])      w_win = 2'd3;
        else if (r_pend[2]) w_win = 2'd2;
        else if (r_pend[1]) w_win = 2'd1;
        else                w_win = 2'd0;
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_gs_l_nxt  = r_gs_l;
        w_clr       = 4'b0000;
        case (r_state)
            ST_IDLE: begin
                if (r_pend != 4'b0000) begin
                    w_idx_nxt   = w_win;
                    w_gs_l_nxt  = 1'b0;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (ACK) begin
                    w_clr       = 4'b0001 << r_idx;
                    w_idx_nxt   = 2'd0;
                    w_gs_l_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // A request arriving with its own clear keeps the bit set.
        w_pend_nxt = (r_pend & ~w_clr) | w_req;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_pend  <= 4'b0000;
            r_idx   <= 2'd0;
            r_gs_l  <= 1'b1;
            r_eo_l  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_idx   <= w_idx_nxt;
            r_gs_l  <= w_gs_l_nxt;
            r_eo_l  <= ~(w_state_nxt == ST_IDLE && w_pend_nxt == 4'b0000 && !EI_L);
        end
    end

    assign A    = r_idx[0];
    assign B    = r_idx[1];
    assign GS_L = r_gs_l;
    assign EO_L = r_eo_l;
    assign PEND = r_pend;

endmodule

`default_nettype wire

// File: tb/tb_irq_encoder_4to2.sv
// ============================================================================
// Module      : tb_irq_encoder_4to2
// Description : Directed self-checking bench for irq_encoder_4to2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_encoder_4to2;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       EI_L;
    logic [3:0] I_L;
    logic       ACK;
    logic       A;
    logic       B;
    logic       GS_L;
    logic       EO_L;
    logic [3:0] PEND;

    int n_vec = 0;
    int n_err = 0;

    irq_encoder_4to2 u_dut (
        .CLK  (CLK),
        .RESET(RESET),
        .EI_L (EI_L),
        .I_L  (I_L),
        .ACK  (ACK),
        .A    (A),
        .B    (B),
        .GS_L (GS_L),
        .EO_L (EO_L),
        .PEND (PEND)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        ACK   = 1'b0;
        I_L   = 4'b1111;
        EI_L  = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
        tick();
    endtask

    logic [1:0] c_rr_exp [5];

    initial begin
`ifdef IRQ_ENC_ROUND_ROBIN_EN
        c_rr_exp = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
`else
        c_rr_exp = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
`endif
        // Reset with every request asserted.
        RESET = 1'b1; EI_L = 1'b0; I_L = 4'b0000; ACK = 1'b1;
        tick();
        tick();
        check("rst_gs",   {7'd0, GS_L}, 8'd1);
        check("rst_ba",   {6'd0, B, A}, 8'd0);
        check("rst_pend", {4'd0, PEND}, 8'h0);
        check("rst_eo",   {7'd0, EO_L}, 8'd1);
        RESET = 1'b0; ACK = 1'b0;
        tick();
        check("rel_pend", {4'd0, PEND}, 8'hf);
        check("rel_gs",   {7'd0, GS_L}, 8'd1);
        I_L = 4'b1111;
        tick();
        check("rel_gs2",  {7'd0, GS_L}, 8'd0);
        check("rel_ba",   {6'd0, B, A}, 8'd3);
        for (int k = 2; k >= 0; k--) begin
            ACK = 1'b1;
            tick();
            check("drain_gap", {7'd0, GS_L}, 8'd1);
            ACK = 1'b0;
            tick();
            check("drain_ba", {6'd0, B, A}, 8'(k));
        end
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        check("drain_pend", {4'd0, PEND}, 8'h0);
        check("drain_eo",   {7'd0, EO_L}, 8'd0);

        // Single request.
        do_reset();
        check("idle_eo", {7'd0, EO_L}, 8'd0);
        I_L = 4'b1101;
        tick();
        I_L = 4'b1111;
        check("single_pend", {4'd0, PEND}, 8'h2);
        check("single_gs0",  {7'd0, GS_L}, 8'd1);
        tick();
        check("single_gs",   {7'd0, GS_L}, 8'd0);
        check("single_ba",   {6'd0, B, A}, 8'd1);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        check("single_rel_gs",   {7'd0, GS_L}, 8'd1);
        check("single_rel_pend", {4'd0, PEND}, 8'h0);
        check("single_rel_eo",   {7'd0, EO_L}, 8'd0);

        // Fixed priority: requests 2 and 0 together.
        do_reset();
        I_L = 4'b1010;
        tick();
        I_L = 4'b1111;
        check("prio_pend", {4'd0, PEND}, 8'h5);
        tick();
        check("prio_ba1", {6'd0, B, A}, 8'd2);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        check("prio_gap", {7'd0, GS_L}, 8'd1);
        tick();
        check("prio_gs2", {7'd0, GS_L}, 8'd0);
        check("prio_ba2", {6'd0, B, A}, 8'd0);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;

        // No preemption; request re-asserted alongside its clear.
        do_reset();
        I_L = 4'b1101;
        tick();
        I_L = 4'b1111;
        tick();
        check("npre_ba1", {6'd0, B, A}, 8'd1);
        I_L = 4'b0111;
        tick();
        check("npre_hold_ba", {6'd0, B, A}, 8'd1);
        check("npre_hold_gs", {7'd0, GS_L}, 8'd0);
        I_L = 4'b0101;
        ACK = 1'b1;
        tick();
        I_L = 4'b1111;
        ACK = 1'b0;
        check("npre_pend", {4'd0, PEND}, 8'ha);
        check("npre_gs",   {7'd0, GS_L}, 8'd1);
        tick();
        check("npre_ba2",  {6'd0, B, A}, 8'd3);

        // Enable gating.
        do_reset();
        EI_L = 1'b1;
        I_L  = 4'b0000;
        tick();
        check("ei_pend", {4'd0, PEND}, 8'h0);
        check("ei_eo",   {7'd0, EO_L}, 8'd1);
        EI_L = 1'b0;
        I_L  = 4'b1011;
        tick();
        check("ei_pend2", {4'd0, PEND}, 8'h4);
        EI_L = 1'b1;
        I_L  = 4'b1111;
        tick();
        check("ei_gs", {7'd0, GS_L}, 8'd0);
        check("ei_ba", {6'd0, B, A}, 8'd2);
        check("ei_eo2", {7'd0, EO_L}, 8'd1);
        EI_L = 1'b0;

        // All requests held: rotation (or not) of the grant order.
        do_reset();
        I_L = 4'b0000;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            check("rr_gs", {7'd0, GS_L}, 8'd0);
            check("rr_ba", {6'd0, B, A}, {6'd0, c_rr_exp[k]});
            ACK = 1'b1;
            tick();
            ACK = 1'b0;
            tick();
        end

        // Reset in the middle of a grant.
        check("mid_gs_pre", {7'd0, GS_L}, 8'd0);
        RESET = 1'b1;
        tick();
        check("mid_gs",   {7'd0, GS_L}, 8'd1);
        check("mid_pend", {4'd0, PEND}, 8'h0);
        check("mid_ba",   {6'd0, B, A}, 8'd0);
        RESET = 1'b0;
        I_L   = 4'b1111;
        tick();
        tick();
        check("mid_idle_gs", {7'd0, GS_L}, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
